// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the front end of the pipeline:
//   - PC width default and NOP encoding
//   - instruction operand field positions (OP1 = [11:8], OP2 = [7:4])
//   - fetch FSM state type
// No ports (package).
// ---------------------------------------------------------------------------
package cpu_pkg;

    localparam int          PC_W_DEFAULT = 8;
    localparam int          INSTR_W      = 16;
    localparam logic [15:0] NOP_INSTR    = 16'h0000;

    // Operand field positions; the NOP keeps both fields zero so that a
    // flushed slot can never look like a register dependency.
    localparam int OP1_HI = 11;
    localparam int OP1_LO = 8;
    localparam int OP2_HI = 7;
    localparam int OP2_LO = 4;

    // FETCH: a request is (or is about to be) on the memory interface.
    // HELD : a fetched instruction waits in the skid buffer, no request out.
    typedef enum logic {
        FETCH = 1'b0,
        HELD  = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/ifid_reg.sv
// ---------------------------------------------------------------------------
// ifid_reg
// One {valid, pc, instr} pipeline slot with flush/load/hold control.
// Used both as the IF/ID register and as the fetch skid buffer.
// Ports:
//   clk, rst                   clock, async active-high reset
//   load                       capture next_* this edge
//   flush                      clear to {0, 0, NOP}; wins over load
//   next_valid/pc/instr        data to capture
//   valid/pc/instr             registered slot contents
// ---------------------------------------------------------------------------
module ifid_reg import cpu_pkg::*; #(
    parameter int          PC_W = PC_W_DEFAULT,
    parameter logic [15:0] NOP  = NOP_INSTR
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic                flush,
    input  logic                next_valid,
    input  logic [PC_W-1:0]     next_pc,
    input  logic [INSTR_W-1:0]  next_instr,
    output logic                valid,
    output logic [PC_W-1:0]     pc,
    output logic [INSTR_W-1:0]  instr
);

    // Flush has priority over load; with neither asserted the slot holds
    // bit-exact, which is what a stall relies on.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            pc    <= '0;
            instr <= NOP;
        end else if (flush) begin
            valid <= 1'b0;
            pc    <= '0;
            instr <= NOP;
        end else if (load) begin
            valid <= next_valid;
            pc    <= next_pc;
            instr <= next_instr;
        end
    end

endmodule

// File: rtl/fetch_ifid_stage.sv
// ---------------------------------------------------------------------------
// fetch_ifid_stage
// Instruction fetch + IF/ID register feeding the hazard detection unit.
// Owns the PC, issues requests on a req/ack instruction-memory handshake,
// holds IF/ID on stall, squashes on a taken branch, and parks a fetch that
// completes during a stall in a one-entry skid buffer.
// Ports:
//   clk, rst                    clock, async active-high reset
//   pcdrive, stall              hazard unit controls (advance = pcdrive & ~stall)
//   branch_taken, branch_target redirect from EX
//   imem_req, imem_addr         fetch request / address (registered)
//   imem_ack, imem_rdata        memory accept + returned instruction
//   ifid_valid/pc/instr         IF/ID contents
//   ifid_op1, ifid_op2          operand fields of ifid_instr
// ---------------------------------------------------------------------------
module fetch_ifid_stage import cpu_pkg::*; #(
    parameter int              PC_W     = PC_W_DEFAULT,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter logic [15:0]     NOP      = NOP_INSTR
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pcdrive,
    input  logic                stall,
    input  logic                branch_taken,
    input  logic [PC_W-1:0]     branch_target,
    output logic                imem_req,
    output logic [PC_W-1:0]     imem_addr,
    input  logic                imem_ack,
    input  logic [INSTR_W-1:0]  imem_rdata,
    output logic                ifid_valid,
    output logic [PC_W-1:0]     ifid_pc,
    output logic [INSTR_W-1:0]  ifid_instr,
    output logic [3:0]          ifid_op1,
    output logic [3:0]          ifid_op2
);

    localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    fetch_state_t       state;
    logic [PC_W-1:0]    pc;
    logic               req;

    logic               advance;
    logic               fetched;
    logic               drain;

    logic               skid_valid;
    logic [PC_W-1:0]    skid_pc;
    logic [INSTR_W-1:0] skid_instr;

    logic               ifid_load;
    logic               skid_load;
    logic               skid_flush;
    logic [PC_W-1:0]    ifid_next_pc;
    logic [INSTR_W-1:0] ifid_next_instr;

    assign advance = pcdrive & ~stall;
    // An ack only counts while our request is actually up; this also masks
    // the first cycle after reset release, before imem_req has risen.
    assign fetched = req & imem_ack;
    assign drain   = (state == HELD) & advance;

    assign ifid_load  = ~branch_taken & ((fetched & advance) | drain);
    assign skid_load  = ~branch_taken & fetched & ~advance;
    assign skid_flush = branch_taken | drain;

    // HELD only ever refills IF/ID from the skid; FETCH takes memory data.
    assign ifid_next_pc    = (state == HELD) ? skid_pc    : pc;
    assign ifid_next_instr = (state == HELD) ? skid_instr : imem_rdata;

    // Fetch FSM. imem_req is registered so it stays low throughout reset
    // and rises on the first edge after release. A taken branch always
    // restarts fetching at the target on the next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FETCH;
            pc    <= RESET_PC;
            req   <= 1'b0;
        end else if (branch_taken) begin
            state <= FETCH;
            pc    <= branch_target;
            req   <= 1'b1;
        end else begin
            case (state)
                FETCH: begin
                    req <= 1'b1;
                    if (fetched) begin
                        pc <= pc + PC_ONE;
                        if (!advance) begin
                            state <= HELD;
                            req   <= 1'b0;
                        end
                    end
                end
                HELD: begin
                    if (advance) begin
                        state <= FETCH;
                        req   <= 1'b1;
                    end
                end
                default: begin
                    state <= FETCH;
                    req   <= 1'b1;
                end
            endcase
        end
    end

    ifid_reg #(.PC_W(PC_W), .NOP(NOP)) u_ifid (
        .clk        (clk),
        .rst        (rst),
        .load       (ifid_load),
        .flush      (branch_taken),
        .next_valid (1'b1),
        .next_pc    (ifid_next_pc),
        .next_instr (ifid_next_instr),
        .valid      (ifid_valid),
        .pc         (ifid_pc),
        .instr      (ifid_instr)
    );

    ifid_reg #(.PC_W(PC_W), .NOP(NOP)) u_skid (
        .clk        (clk),
        .rst        (rst),
        .load       (skid_load),
        .flush      (skid_flush),
        .next_valid (1'b1),
        .next_pc    (pc),
        .next_instr (imem_rdata),
        .valid      (skid_valid),
        .pc         (skid_pc),
        .instr      (skid_instr)
    );

    assign imem_req  = req;
    assign imem_addr = pc;
    assign ifid_op1  = ifid_instr[OP1_HI:OP1_LO];
    assign ifid_op2  = ifid_instr[OP2_HI:OP2_LO];

endmodule
